// File: rtl/spram_word_seq.sv
// Word-to-segment sequencer for a segmented single-port SRAM.
// One WORD_WIDTH request is split into NUM_SEGS SEG_WIDTH accesses issued in ascending order.
module spram_word_seq #(
  parameter int WORD_WIDTH = 128,
  parameter int SEG_WIDTH  = 16,
  parameter int NUM_SEGS   = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_seg_sel,
  output logic [SEG_WIDTH-1:0]  mem_wdata,
  input  logic [SEG_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;

  localparam logic [2:0] LAST = 3'(NUM_SEGS - 1);

  state_t                state;
  logic [2:0]            seg_cnt;
  logic [2:0]            cap_cnt;
  logic [2:0]            seg_nxt;
  logic [WORD_WIDTH-1:0] wr_word;

  assign seg_nxt     = seg_cnt + 3'd1;
  assign mem_seg_sel = seg_cnt;

  // All outputs are registers so reset can drop the SRAM strobes asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      seg_cnt   <= 3'd0;
      cap_cnt   <= 3'd0;
      wr_word   <= '0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      // Read data trails the strobe by one cycle, so capture runs on through DRAIN.
      if ((state == READ || state == DRAIN) && mem_ready) begin
        rsp_rdata[int'(cap_cnt)*SEG_WIDTH +: SEG_WIDTH] <= mem_rdata;
        cap_cnt <= cap_cnt + 3'd1;
      end

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            mem_addr  <= req_addr;
            seg_cnt   <= 3'd0;
            cap_cnt   <= 3'd0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_wr) begin
              wr_word   <= req_wdata;
              mem_wen   <= 1'b1;
              mem_wdata <= req_wdata[SEG_WIDTH-1:0];
              state     <= WRITE;
            end else begin
              mem_ren <= 1'b1;
              state   <= READ;
            end
          end
        end

        WRITE: begin
          if (seg_cnt == LAST) begin
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            seg_cnt   <= 3'd0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            seg_cnt   <= seg_nxt;
            mem_wdata <= wr_word[int'(seg_nxt)*SEG_WIDTH +: SEG_WIDTH];
          end
        end

        READ: begin
          if (seg_cnt == LAST) begin
            mem_ren <= 1'b0;
            seg_cnt <= 3'd0;
            state   <= DRAIN;
          end else begin
            seg_cnt <= seg_nxt;
          end
        end

        DRAIN: begin
          if (mem_ready && cap_cnt == LAST) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_word_seq.sv
// Directed bench for spram_word_seq with a one-cycle-latency segmented SRAM model.
module tb_spram_word_seq;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [10:0]  req_addr;
  logic [127:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_rdata;
  logic         busy;
  logic         mem_wen;
  logic         mem_ren;
  logic [10:0]  mem_addr;
  logic [2:0]   mem_seg_sel;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_ready;

  int total = 0;
  int bad   = 0;

  logic [127:0] sram [0:2047];

  localparam logic [127:0] W1    = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] W2    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] WTOP  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
  localparam logic [127:0] WJUNK = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_7777;

  spram_word_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_addr   (mem_addr),
    .mem_seg_sel(mem_seg_sel),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered segment SRAM: read data and its qualifier appear one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (mem_wen)
      sram[mem_addr][int'(mem_seg_sel)*16 +: 16] <= mem_wdata;
    mem_ready <= mem_ren;
    mem_rdata <= sram[mem_addr][int'(mem_seg_sel)*16 +: 16];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [10:0] addr, input logic [127:0] data);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = data;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_req_ready", 128'(req_ready), 128'(1));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_rdata", rsp_rdata,       128'(0));
    chk("rst_strobes",   128'({mem_wen, mem_ren}), 128'(0));
    chk("rst_seg_sel",   128'(mem_seg_sel), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    step();

    // Word write to address 5: eight segment strobes with ascending data.
    issue(1'b1, 11'd5, W1);
    for (int k = 0; k < 8; k++) begin
      chk("wr_wen",     128'(mem_wen),     128'(1));
      chk("wr_ren",     128'(mem_ren),     128'(0));
      chk("wr_seg_sel", 128'(mem_seg_sel), 128'(k));
      chk("wr_wdata",   128'(mem_wdata),   128'(k));
      chk("wr_addr",    128'(mem_addr),    128'(5));
      chk("wr_ready",   128'(req_ready),   128'(0));
      chk("wr_busy",    128'(busy),        128'(1));
      step();
    end
    chk("wr_done_ready", 128'(req_ready), 128'(1));
    chk("wr_done_wen",   128'(mem_wen),   128'(0));
    chk("wr_done_wdata", 128'(mem_wdata), 128'(0));
    chk("wr_no_rsp",     128'(rsp_valid), 128'(0));
    chk("wr_sram",       sram[5],         W1);

    // Word read from address 5 with the consumer always ready.
    rsp_ready = 1'b1;
    issue(1'b0, 11'd5, WJUNK);
    for (int k = 0; k < 8; k++) begin
      chk("rd_ren",     128'(mem_ren),     128'(1));
      chk("rd_wen",     128'(mem_wen),     128'(0));
      chk("rd_seg_sel", 128'(mem_seg_sel), 128'(k));
      chk("rd_wdata",   128'(mem_wdata),   128'(0));
      chk("rd_rsp_early", 128'(rsp_valid), 128'(0));
      step();
    end
    chk("rd_drain_ren",   128'(mem_ren),   128'(0));
    chk("rd_drain_busy",  128'(busy),      128'(1));
    chk("rd_drain_valid", 128'(rsp_valid), 128'(0));
    step();
    chk("rd_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("rd_rsp_data",  rsp_rdata,       W1);
    step();
    chk("rd_pulse_end", 128'(rsp_valid), 128'(0));
    chk("rd_idle",      128'(req_ready), 128'(1));
    chk("rd_sram_kept", sram[5],         W1);

    // Top address with the consumer stalling; new requests must be ignored meanwhile.
    issue(1'b1, 11'd2047, WTOP);
    for (int k = 0; k < 8; k++) step();
    chk("top_wr_sram", sram[2047], WTOP);
    rsp_ready = 1'b0;
    issue(1'b0, 11'd2047, '0);
    for (int k = 0; k < 8; k++) begin
      chk("top_addr", 128'(mem_addr), 128'(2047));
      step();
    end
    step();
    chk("top_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("top_rsp_data",  rsp_rdata,       WTOP);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 11'd2047;
    req_wdata = WJUNK;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_valid",   128'(rsp_valid), 128'(1));
      chk("stall_data",    rsp_rdata,       WTOP);
      chk("stall_ready",   128'(req_ready), 128'(0));
      chk("stall_strobes", 128'({mem_wen, mem_ren}), 128'(0));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("stall_release_valid", 128'(rsp_valid), 128'(0));
    chk("stall_release_busy",  128'(busy),      128'(0));
    chk("stall_release_ready", 128'(req_ready), 128'(1));
    chk("stall_sram_kept",     sram[2047],      WTOP);

    // Back-to-back write then read with req_valid held high throughout.
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 11'd9;
    req_wdata = W2;
    step();
    req_wr    = 1'b0;
    req_wdata = WJUNK;
    for (int k = 0; k < 8; k++) begin
      chk("b2b_wr_ready", 128'(req_ready), 128'(0));
      chk("b2b_wr_ren",   128'(mem_ren),   128'(0));
      step();
    end
    chk("b2b_ready_back", 128'(req_ready), 128'(1));
    step();
    req_valid = 1'b0;
    chk("b2b_rd_accept", 128'(mem_ren),     128'(1));
    chk("b2b_rd_wen",    128'(mem_wen),     128'(0));
    chk("b2b_rd_seg0",   128'(mem_seg_sel), 128'(0));
    for (int k = 0; k < 8; k++) begin
      chk("b2b_no_overlap", 128'(mem_wen & mem_ren), 128'(0));
      step();
    end
    step();
    chk("b2b_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("b2b_rsp_data",  rsp_rdata,       W2);
    step();

    // Reset in the middle of a read, then a clean re-read of the same word.
    issue(1'b0, 11'd5, '0);
    for (int k = 0; k < 4; k++) step();
    chk("abort_seg4", 128'(mem_seg_sel), 128'(4));
    rst = 1'b1;
    #1;
    chk("abort_ren",   128'(mem_ren),   128'(0));
    chk("abort_busy",  128'(busy),      128'(0));
    chk("abort_valid", 128'(rsp_valid), 128'(0));
    chk("abort_ready", 128'(req_ready), 128'(1));
    step();
    rst = 1'b0;
    step();
    chk("abort_no_strobe", 128'({mem_wen, mem_ren}), 128'(0));
    issue(1'b0, 11'd5, '0);
    for (int k = 0; k < 9; k++) step();
    chk("reread_valid", 128'(rsp_valid), 128'(1));
    chk("reread_data",  rsp_rdata,       W1);
    step();
    chk("reread_idle", 128'(busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spram_word_seq.md
SPRAM_WORD_SEQ -- requirements
Module: spram_word_seq

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 128, full word width.
REQ-002 SHALL have parameter SEG_WIDTH, default 16, segment width.
REQ-003 SHALL have parameter NUM_SEGS, default 8, segments per word (WORD_WIDTH/SEG_WIDTH).
REQ-004 SHALL have parameter ADDR_WIDTH, default 11, word address width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port req_valid, input, 1, word request present.
REQ-008 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-009 SHALL have port req_wr, input, 1, 1=write word, 0=read word.
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH, word address.
REQ-011 SHALL have port req_wdata, input, WORD_WIDTH, write word.
REQ-012 SHALL have port rsp_valid, output, 1, read word available.
REQ-013 SHALL have port rsp_ready, input, 1, consumer takes read word.
REQ-014 SHALL have port rsp_rdata, output, WORD_WIDTH, assembled read word.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 SHALL have port mem_wen, output, 1, segment write strobe to the segmented SRAM.
REQ-017 SHALL have port mem_ren, output, 1, segment read strobe.
REQ-018 SHALL have port mem_addr, output, ADDR_WIDTH, SRAM word address.
REQ-019 SHALL have port mem_seg_sel, output, 3, segment select.
REQ-020 SHALL have port mem_wdata, output, SEG_WIDTH, segment write data.
REQ-021 SHALL have port mem_rdata, input, SEG_WIDTH, registered segment read data (valid one cycle after mem_ren).
REQ-022 SHALL have port mem_ready, input, 1, qualifies mem_rdata.

Function
REQ-023 SHALL implement states IDLE, WRITE, READ, DRAIN, RESP.
REQ-024 SHALL drive req_ready high only in IDLE.
REQ-025 SHALL, in IDLE on edge with req_valid&req_ready, latch req_addr (and req_wdata when req_wr=1), clear seg counter, go WRITE if req_wr else READ.
REQ-026 SHALL map segment k to word bits [16k+15:16k], k=0..7, issued in ascending order.
REQ-027 SHALL, in WRITE, drive mem_wen=1, mem_seg_sel=counter, mem_wdata=latched segment[counter]; counter+1 per cycle; after segment 7 go IDLE.
REQ-028 SHALL complete a write accepted at edge N with SRAM writes at edges N+1..N+8 and req_ready high again after edge N+8; writes produce no response.
REQ-029 SHALL, in READ, drive mem_ren=1, mem_seg_sel=counter, counter+1 per cycle; after segment 7 go DRAIN.
REQ-030 SHALL, in READ and DRAIN, on each edge with mem_ready=1, store mem_rdata into segment[capture counter] of rsp_rdata and increment capture counter; mem_ready ignored in other states.
REQ-031 SHALL leave DRAIN for RESP on the edge that captures segment 7, so a read accepted at edge N asserts rsp_valid from edge N+9.
REQ-032 SHALL hold rsp_valid and rsp_rdata stable in RESP until rsp_ready=1, then go IDLE on that edge.
REQ-033 SHALL keep mem_addr equal to the latched address for the whole operation; no address wrap (2047 legal).
REQ-034 SHALL drive mem_wen=0, mem_ren=0, mem_wdata=0, mem_seg_sel=0 outside WRITE/READ.
REQ-035 SHALL never assert mem_wen and mem_ren in the same cycle.
REQ-036 SHALL ignore req_valid while busy; SHALL ignore req_wdata for reads.

Reset
REQ-037 SHALL, while rst=1, force state IDLE, counters 0, rsp_valid=0, rsp_rdata=0, busy=0, mem_wen=0, mem_ren=0, req_ready=1.
REQ-038 SHALL, on rst mid-operation, abort immediately with no further SRAM strobes; partially written segments remain in SRAM.

Verification
REQ-039 Write 0x0007_0006_0005_0004_0003_0002_0001_0000 to addr 5 -> mem_wen 8 cycles, seg_sel 0..7, mem_wdata 0x0000..0x0007, req_ready low 8 cycles.
REQ-040 Read addr 5 after REQ-039 with rsp_ready=1 -> rsp_valid at edge N+9, rsp_rdata equals written word, one-cycle pulse.
REQ-041 Read addr 2047 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held stable, req_valid ignored, IDLE after rsp_ready=1.
REQ-042 Back-to-back write then read with req_valid held high -> second request accepted the cycle req_ready returns; no overlapping strobes.
REQ-043 rst=1 during READ segment 4 -> mem_ren=0 asynchronously, rsp_valid=0, busy=0; subsequent read of same addr returns full correct word.
